// File: rtl/bcd_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_seq_pkg : shared types and constants for the BCD load sequencer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bcd_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam int unsigned NSLOTS  = 4;
  localparam int unsigned SLOT_W  = 2;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NSLOTS - 1);

endpackage
`default_nettype wire

// File: rtl/bcd_sum_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_sum_seq : sequences four BCD digit loads into a summing datapath |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bcd_sum_seq
  import bcd_seq_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       din_valid,
  input  logic [3:0] din,
  output logic       din_ready,
  output logic [3:0] entrada,
  output logic       EN1,
  output logic       EN2,
  output logic       EN3,
  output logic       EN4,
  output logic       dp_clr,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] slot
);

  localparam logic [3:0] C_SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t            r_state, w_state_nxt;
  logic [SLOT_W-1:0] r_slot,  w_slot_nxt;
  logic [3:0]        r_cnt,   w_cnt_nxt;
  logic [3:0]        w_en;
  logic              w_ready, w_clr, w_busy, w_done, w_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_slot  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_cnt_nxt   = r_cnt;
    w_en        = 4'b0000;
    w_ready     = 1'b0;
    w_clr       = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_err       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_CLR;
      end
      ST_CLR: begin
        w_clr      = 1'b1;
        w_busy     = 1'b1;
        w_slot_nxt = '0;
        w_state_nxt = abort ? ST_IDLE : ST_LOAD;
      end
      ST_LOAD: begin
        w_busy = 1'b1;
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_ready = 1'b1;
          if (din_valid) begin
            if (din > BCD_MAX) begin
              w_state_nxt = ST_ERR;
            end else begin
              w_en[r_slot] = 1'b1;
              if (r_slot == LAST_SLOT) begin
                w_cnt_nxt   = '0;
                w_state_nxt = (SETTLE == 0) ? ST_DONE : ST_SETTLE;
              end else begin
                w_slot_nxt = r_slot + 1'b1;
              end
            end
          end
        end
      end
      ST_SETTLE: begin
        w_busy = 1'b1;
        if (abort)                       w_state_nxt = ST_IDLE;
        else if (r_cnt == C_SETTLE_LAST) w_state_nxt = ST_DONE;
        else                             w_cnt_nxt   = r_cnt + 4'd1;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        w_err = 1'b1;
        if (abort)      w_state_nxt = ST_IDLE;
        else if (start) w_state_nxt = ST_CLR;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Reset blanks every strobe immediately so no slot loads in the reset cycle.
    if (rst) begin
      w_en    = 4'b0000;
      w_ready = 1'b0;
      w_clr   = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      w_err   = 1'b0;
    end
  end

  assign entrada   = din;
  assign EN1       = w_en[0];
  assign EN2       = w_en[1];
  assign EN3       = w_en[2];
  assign EN4       = w_en[3];
  assign din_ready = w_ready;
  assign dp_clr    = w_clr;
  assign busy      = w_busy;
  assign done      = w_done;
  assign err       = w_err;
  assign slot      = r_slot;

endmodule
`default_nettype wire

// File: tb/tb_bcd_sum_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bcd_sum_seq : scoreboard bench for bcd_sum_seq (SETTLE 1, 3, 0)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bcd_sum_seq;

  logic       clk = 1'b0;
  logic       rst, start, abort, din_valid;
  logic [3:0] din;

  logic       rdy1, en1a, en1b, en1c, en1d, clr1, busy1, done1, err1;
  logic [3:0] ent1;
  logic [1:0] slot1;
  logic       rdy3, en3a, en3b, en3c, en3d, clr3, busy3, done3, err3;
  logic [3:0] ent3;
  logic [1:0] slot3;
  logic       rdy0, en0a, en0b, en0c, en0d, clr0, busy0, done0, err0;
  logic [3:0] ent0;
  logic [1:0] slot0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] q_en [$];
  logic [7:0] q_sum[$];

  always #5 clk = ~clk;

  bcd_sum_seq #(.SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .din_valid(din_valid), .din(din),
    .din_ready(rdy1), .entrada(ent1), .EN1(en1a), .EN2(en1b), .EN3(en1c), .EN4(en1d),
    .dp_clr(clr1), .busy(busy1), .done(done1), .err(err1), .slot(slot1));

  bcd_sum_seq #(.SETTLE(3)) u3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .din_valid(din_valid), .din(din),
    .din_ready(rdy3), .entrada(ent3), .EN1(en3a), .EN2(en3b), .EN3(en3c), .EN4(en3d),
    .dp_clr(clr3), .busy(busy3), .done(done3), .err(err3), .slot(slot3));

  bcd_sum_seq #(.SETTLE(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .din_valid(din_valid), .din(din),
    .din_ready(rdy0), .entrada(ent0), .EN1(en0a), .EN2(en0b), .EN3(en0c), .EN4(en0d),
    .dp_clr(clr0), .busy(busy0), .done(done0), .err(err0), .slot(slot0));

  wire [3:0] en1 = {en1a, en1b, en1c, en1d};
  wire [3:0] en3 = {en3a, en3b, en3c, en3d};

  // Behavioural datapath behind u1: four digit slots and a BCD adder chain.
  logic [3:0] md1, md2, md3, md4;
  logic [7:0] dp_s;

  function automatic logic [7:0] bcd_acc(input logic [7:0] acc, input logic [3:0] d);
    logic [4:0] lo;
    logic [3:0] hi;
    lo = {1'b0, acc[3:0]} + {1'b0, d};
    hi = acc[7:4];
    if (lo > 5'd9) begin
      lo = lo + 5'd6;
      hi = hi + 4'd1;
    end
    return {hi, lo[3:0]};
  endfunction

  always @(posedge clk) begin
    if (rst || clr1) begin
      md1 <= 4'd0; md2 <= 4'd0; md3 <= 4'd0; md4 <= 4'd0;
    end else begin
      if (en1a) md1 <= ent1;
      if (en1b) md2 <= ent1;
      if (en1c) md3 <= ent1;
      if (en1d) md4 <= ent1;
    end
  end

  always_comb dp_s = bcd_acc(bcd_acc(bcd_acc(bcd_acc(8'h00, md1), md2), md3), md4);

  // One clock: inputs change 1 ns after the rising edge, caller samples at the falling edge.
  task automatic drive(input logic r, input logic s, input logic a, input logic v, input logic [3:0] d);
    @(posedge clk);
    #1;
    rst = r; start = s; abort = a; din_valid = v; din = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    q_en.delete();
    q_sum.delete();
  endtask

  task automatic test_reset();
    logic [3:0] e;
    rst = 1; start = 1; abort = 0; din_valid = 0; din = 0;
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    n_cmp++; if ({busy1, done1, err1, clr1, rdy1} !== 5'b0) begin n_bad++;
      $display("FAIL reset_status: got %b want 00000", {busy1, done1, err1, clr1, rdy1}); end
    n_cmp++; if (slot1 !== 2'd0) begin n_bad++; $display("FAIL reset_slot: got %0d want 0", slot1); end
    drive(0, 0, 0, 0, 0);
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy1); end
    // Reset arriving in LOAD with a valid digit must suppress the load.
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 4'd5);
    q_en.push_back(4'b1000);
    e = q_en.pop_front();
    n_cmp++; if (en1 !== e) begin n_bad++; $display("FAIL reset_pre_load: got %b want %b", en1, e); end
    drive(1, 0, 0, 1, 4'd6);
    n_cmp++; if ({en1, rdy1, busy1} !== 6'b0) begin n_bad++;
      $display("FAIL reset_mid_load: got %b want 000000", {en1, rdy1, busy1}); end
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({slot1, busy1} !== 3'b0) begin n_bad++;
      $display("FAIL reset_mid_after: got %b want 000", {slot1, busy1}); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] dg;
    logic [3:0]  d, e;
    int          tot;
    do_reset();
    dg  = 16'h3124;
    tot = 0;
    drive(0, 1, 0, 0, 0);
    n_cmp++; if (clr1 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_clr: got %b want 0", clr1); end
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({clr1, busy1} !== 2'b11) begin n_bad++; $display("FAIL b2b_clr: got %b want 11", {clr1, busy1}); end
    for (int i = 0; i < 4; i++) begin
      d = dg[15-4*i -: 4];
      tot += int'(d);
      drive(0, 0, 0, 1, d);
      q_en.push_back(4'b1000 >> i);
      e = q_en.pop_front();
      n_cmp++; if ({en1, slot1, rdy1} !== {e, 2'(i), 1'b1}) begin n_bad++;
        $display("FAIL b2b_load%0d: got en=%b slot=%0d rdy=%b want en=%b slot=%0d rdy=1", i, en1, slot1, rdy1, e, i); end
    end
    q_sum.push_back({4'(tot / 10), 4'(tot % 10)});
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({done1, busy1, en1} !== 6'b010000) begin n_bad++;
      $display("FAIL b2b_settle: got done=%b busy=%b en=%b want 0 1 0000", done1, busy1, en1); end
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({done1, busy1} !== 2'b10) begin n_bad++; $display("FAIL b2b_done: got %b want 10", {done1, busy1}); end
    e = 0;
    begin
      logic [7:0] es;
      es = q_sum.pop_front();
      n_cmp++; if (dp_s !== es) begin n_bad++; $display("FAIL b2b_sum: got %h want %h", dp_s, es); end
    end
    drive(0, 0, 0, 0, 0);
    n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL b2b_done_pulse: got %b want 0", done1); end
  endtask

  task automatic test_stalls();
    logic [3:0] e;
    logic [7:0] es;
    do_reset();
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          drive(0, 0, 0, 0, 4'd5);
          q_en.push_back(4'b0000);
          e = q_en.pop_front();
          n_cmp++; if ({en1, slot1} !== {e, 2'(i)}) begin n_bad++;
            $display("FAIL stall_gap%0d_%0d: got en=%b slot=%0d want en=%b slot=%0d", i, g, en1, slot1, e, i); end
        end
      end
      drive(0, 0, 0, 1, 4'd5);
      q_en.push_back(4'b1000 >> i);
      e = q_en.pop_front();
      n_cmp++; if (en1 !== e) begin n_bad++; $display("FAIL stall_load%0d: got %b want %b", i, en1, e); end
    end
    q_sum.push_back(8'h20);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    es = q_sum.pop_front();
    n_cmp++; if ({done1, dp_s} !== {1'b1, es}) begin n_bad++;
      $display("FAIL stall_done_sum: got done=%b s=%h want done=1 s=%h", done1, dp_s, es); end
  endtask

  task automatic test_non_bcd();
    logic [11:0] dg;
    logic [3:0]  e;
    do_reset();
    dg = 12'h27A;
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, dg[11-4*i -: 4]);
      q_en.push_back(i < 2 ? (4'b1000 >> i) : 4'b0000);
      e = q_en.pop_front();
      n_cmp++; if ({en1, err1} !== {e, 1'b0}) begin n_bad++;
        $display("FAIL nbcd_load%0d: got en=%b err=%b want en=%b err=0", i, en1, err1, e); end
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 4'd1);
      n_cmp++; if ({err1, busy1, en1, rdy1} !== 7'b1000000) begin n_bad++;
        $display("FAIL nbcd_err_hold%0d: got err=%b busy=%b en=%b rdy=%b want 1 0 0000 0", k, err1, busy1, en1, rdy1); end
    end
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({err1, clr1} !== 2'b01) begin n_bad++; $display("FAIL nbcd_restart: got err,clr=%b want 01", {err1, clr1}); end
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({busy1, err1} !== 2'b00) begin n_bad++; $display("FAIL nbcd_abort_idle: got %b want 00", {busy1, err1}); end
  endtask

  task automatic test_abort_start();
    logic [3:0] e;
    logic [7:0] es;
    do_reset();
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 4'd1);
    drive(0, 0, 1, 1, 4'd2);
    q_en.push_back(4'b0000);
    e = q_en.pop_front();
    n_cmp++; if ({en1, rdy1} !== {e, 1'b0}) begin n_bad++;
      $display("FAIL abort_digit: got en=%b rdy=%b want en=%b rdy=0", en1, rdy1, e); end
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({busy1, clr1, en1} !== 6'b0) begin n_bad++; $display("FAIL abort_idle: got %b want 000000", {busy1, clr1, en1}); end
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 0, 0);
      n_cmp++; if ({en1, slot1, clr1} !== {4'b0000, 2'(i), 1'b0}) begin n_bad++;
        $display("FAIL start_in_load%0d: got en=%b slot=%0d clr=%b want 0000 %0d 0", i, en1, slot1, clr1, i); end
      drive(0, 1, 0, 1, 4'd9);
      q_en.push_back(4'b1000 >> i);
      e = q_en.pop_front();
      n_cmp++; if (en1 !== e) begin n_bad++; $display("FAIL start_load%0d: got %b want %b", i, en1, e); end
    end
    q_sum.push_back(8'h36);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    es = q_sum.pop_front();
    n_cmp++; if ({done1, dp_s} !== {1'b1, es}) begin n_bad++;
      $display("FAIL start_done_sum: got done=%b s=%h want done=1 s=%h", done1, dp_s, es); end
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({busy1, clr1, done1} !== 3'b000) begin n_bad++;
      $display("FAIL start_in_done_ignored: got %b want 000", {busy1, clr1, done1}); end
  endtask

  task automatic test_settle_variants();
    do_reset();
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 4'(i + 1));
    drive(0, 0, 0, 0, 0);
    n_cmp++; if ({done0, done1, busy3} !== 3'b101) begin n_bad++;
      $display("FAIL settle_l1: got done0,done1,busy3=%b want 101", {done0, done1, busy3}); end
    drive(1, 0, 0, 1, 4'd3);
    n_cmp++; if ({busy3, done3, err3, clr3, rdy3, en3, done1} !== 10'b0) begin n_bad++;
      $display("FAIL settle3_rst: got %b want 0000000000", {busy3, done3, err3, clr3, rdy3, en3, done1}); end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0);
      n_cmp++; if ({busy3, done3, slot3} !== 4'b0) begin n_bad++;
        $display("FAIL settle3_after_rst%0d: got %b want 0000", k, {busy3, done3, slot3}); end
    end
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 4'd2);
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 0, 0, 0);
      n_cmp++; if ({done0, done1, done3} !== {k == 1, k == 2, k == 4}) begin n_bad++;
        $display("FAIL settle_done_L+%0d: got done0,1,3=%b want %b", k, {done0, done1, done3}, {k == 1, k == 2, k == 4}); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = 4'd0;
    test_reset();
    test_back_to_back();
    test_stalls();
    test_non_bcd();
    test_abort_start();
    test_settle_variants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_sum_seq.md
BCD_SUM_SEQ -- requirements
Module: bcd_sum_seq

Interface
REQ-001 SHALL expose parameter SETTLE, default 1, meaning the number of wait cycles after the 4th digit load before done (datapath sum latency, range 0..15).
REQ-002 SHALL expose port clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL expose port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL expose port start  in  1  request to begin a 4-digit sequence.
REQ-005 SHALL expose port abort  in  1  cancel the current sequence.
REQ-006 SHALL expose port din_valid  in  1  the digit on din is offered.
REQ-007 SHALL expose port din  in  4  BCD digit from the source.
REQ-008 SHALL expose port din_ready  out  1  controller accepts a digit this cycle.
REQ-009 SHALL expose port entrada  out  4  digit forwarded to the datapath (combinational copy of din).
REQ-010 SHALL expose ports EN1, EN2, EN3, EN4  out  1 each  one-hot load enables for datapath slots 1..4.
REQ-011 SHALL expose port dp_clr  out  1  clear pulse to the datapath registers.
REQ-012 SHALL expose ports busy, done, err  out  1 each  status outputs.
REQ-013 SHALL expose port slot  out  2  index of the next slot to load.

Function
REQ-014 FSM states SHALL be IDLE, CLR, LOAD, SETTLE, DONE, ERR.
REQ-015 IDLE: start=1 SHALL go to CLR; otherwise stay.
REQ-016 CLR: dp_clr=1 for exactly this one cycle; slot:=0; next state LOAD.
REQ-017 LOAD: din_ready=1; a digit is accepted when din_valid & din_ready.
REQ-018 On an accepted digit with din<=9, EN(slot+1) SHALL be 1 in that same cycle (combinational); all other ENs SHALL be 0.
REQ-019 On an accepted digit with slot<3, slot SHALL increment; with slot=3, next state SHALL be SETTLE.
REQ-020 On an accepted digit with din>9, all ENs SHALL be 0 and next state SHALL be ERR.
REQ-021 LOAD with din_valid=0 SHALL hold state and slot, with ENs 0 (stalls of any length allowed).
REQ-022 SETTLE SHALL last exactly SETTLE cycles, then go to DONE; SETTLE=0 SHALL go from LOAD directly to DONE.
REQ-023 DONE: done=1 for one cycle, then IDLE; start during DONE SHALL be ignored.
REQ-024 ERR: err=1 held; start SHALL go to CLR, with err dropping in CLR; abort SHALL go to IDLE.
REQ-025 busy SHALL be 1 in CLR, LOAD, and SETTLE; 0 otherwise.
REQ-026 start in CLR, LOAD, or SETTLE SHALL be ignored.
REQ-027 abort in CLR, LOAD, or SETTLE SHALL force all ENs and din_ready to 0 in that cycle and go to IDLE next; abort has priority over a simultaneous digit.
REQ-028 At most one EN SHALL be high in any cycle; ENs SHALL be 0 outside LOAD.
REQ-029 Latency: start accepted at cycle T gives dp_clr at T+1, first possible load at T+2, and done at L+SETTLE+1, where L is the 4th accept cycle.

Reset
REQ-030 rst=1 SHALL force state IDLE and slot 0 on the next edge, overriding start and abort.
REQ-031 While rst=1, EN1..EN4, din_ready, dp_clr, done, err, and busy SHALL be 0 combinationally, so no load occurs during reset mid-sequence.

Structure
REQ-032 Package bcd_seq_pkg SHALL hold the state enum, BCD_MAX=9, NSLOTS=4, and the slot width.
REQ-033 SHALL be a single module with no sub-module; the settle counter is inline, 4 bits wide.

Verification
REQ-034 Sequence: rst for 2 cycles, start, then din 3,1,2,4 back-to-back -> dp_clr one cycle, then EN pattern 1000,0100,0010,0001 on consecutive cycles, done 2 cycles after the last load (SETTLE=1), datapath s=8'h10.
REQ-035 Stalls: digits 5,5,5,5 with din_valid low 3 cycles between digits -> ENs only on accept cycles, slot holds during gaps, s=8'h20.
REQ-036 Non-BCD digit: din 2,7,A -> EN1 and EN2 only, no EN3, err=1 from the next cycle and held; start -> err cleared and dp_clr pulse.
REQ-037 Abort and start while busy: abort asserted together with 2nd digit valid -> no EN2, IDLE next, busy=0; start pulses during LOAD -> no effect on slot.
REQ-038 Reset mid-SETTLE (SETTLE=3): rst in 2nd settle cycle -> no done, IDLE, all outputs 0; SETTLE=0 run -> done the cycle after the 4th load.
